range_step_counter: RTL and testbench

//  Parametrised successor to the basic up-counter. Adds up/down counting, programmable step,

---
 rtl/range_step_counter.sv | 141 ++++++++++++++
 tb/tb_range_step_counter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/range_step_counter.sv
// range_step_counter: up/down counter with programmable step, window and end mode.
// Optional prescaler under RANGE_CNT_PRESCALE_EN.
//
// Ports:
//   clk, rst      rising-edge clock and synchronous active-high reset
//   en, up        count enable and direction (1 = up)
//   load          synchronous load of load_value
//   init_value    value taken on rst
//   step          amount added or subtracted per counting cycle
//   lo/hi_limit   inclusive window bounds
//   mode          00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   prescale      count every prescale+1 enabled cycles (macro only)
//   data          registered count
//   co            data is at the bound for the current direction
//   bnd           one-cycle pulse after a boundary event
//   done          sticky one-shot completion flag
module range_step_counter #(
  parameter int SIZE = 8
`ifdef RANGE_CNT_PRESCALE_EN
  ,
  parameter int PRE_W = 4
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            up,
  input  logic            load,
  input  logic [SIZE-1:0] load_value,
  input  logic [SIZE-1:0] init_value,
  input  logic [SIZE-1:0] step,
  input  logic [SIZE-1:0] lo_limit,
  input  logic [SIZE-1:0] hi_limit,
  input  logic [1:0]      mode,
`ifdef RANGE_CNT_PRESCALE_EN
  input  logic [PRE_W-1:0] prescale,
`endif
  output logic [SIZE-1:0] data,
  output logic            co,
  output logic            bnd,
  output logic            done
);

  localparam logic [1:0] MODE_SAT = 2'b01;
  localparam logic [1:0] MODE_ONE = 2'b10;

  logic [SIZE-1:0] data_q, data_d;
  logic            bnd_q, bnd_d;
  logic            done_q, done_d;
  logic [SIZE:0]   sum, diff;
  logic            hit_up, hit_dn, hit;
  logic            active, cnt_cycle;
  logic            is_sat, is_one;

`ifdef RANGE_CNT_PRESCALE_EN
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             pre_term;

  assign pre_term = (pre_q == prescale);
`endif

  assign is_sat = (mode == MODE_SAT);
  assign is_one = (mode == MODE_ONE);

  // Extra top bit carries overflow/borrow so no step ever wraps silently.
  assign sum    = {1'b0, data_q} + {1'b0, step};
  assign diff   = {1'b0, data_q} - {1'b0, step};
  assign hit_up = sum > {1'b0, hi_limit};
  assign hit_dn = diff[SIZE] | (diff < {1'b0, lo_limit});
  assign hit    = up ? hit_up : hit_dn;

  assign active = en & ~done_q;
`ifdef RANGE_CNT_PRESCALE_EN
  assign cnt_cycle = active & pre_term;
`else
  assign cnt_cycle = active;
`endif

  always_comb begin
    data_d = data_q;
    bnd_d  = 1'b0;
    done_d = done_q;
`ifdef RANGE_CNT_PRESCALE_EN
    pre_d  = pre_q;
`endif
    if (load) begin
      data_d = load_value;
      done_d = 1'b0;
`ifdef RANGE_CNT_PRESCALE_EN
      pre_d  = '0;
`endif
    end else begin
`ifdef RANGE_CNT_PRESCALE_EN
      if (active) begin
        pre_d = pre_term ? '0 : pre_q + 1'b1;
      end
`endif
      if (cnt_cycle) begin
        if (hit) begin
          bnd_d = 1'b1;
          // Saturate and one-shot park on the bound being crossed;
          // wrap jumps to the opposite bound.
          if (is_sat || is_one) begin
            data_d = up ? hi_limit : lo_limit;
          end else begin
            data_d = up ? lo_limit : hi_limit;
          end
          if (is_one) begin
            done_d = 1'b1;
          end
        end else begin
          data_d = up ? sum[SIZE-1:0] : diff[SIZE-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= init_value;
      bnd_q  <= 1'b0;
      done_q <= 1'b0;
`ifdef RANGE_CNT_PRESCALE_EN
      pre_q  <= '0;
`endif
    end else begin
      data_q <= data_d;
      bnd_q  <= bnd_d;
      done_q <= done_d;
`ifdef RANGE_CNT_PRESCALE_EN
      pre_q  <= pre_d;
`endif
    end
  end

  assign data = data_q;
  assign bnd  = bnd_q;
  assign done = done_q;
  assign co   = (data_q == (up ? hi_limit : lo_limit));

endmodule

// File: tb/tb_range_step_counter.sv
// Testbench for range_step_counter (SIZE=8).
// Expected results are queued as stimulus is applied and checked after the edge.
module tb_range_step_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [7:0] load_value, init_value, step, lo_limit, hi_limit;
  logic [1:0] mode;
  logic [7:0] data;
  logic       co, bnd, done;
`ifdef RANGE_CNT_PRESCALE_EN
  logic [3:0] prescale;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       bnd;
    logic       done;
    logic       co;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_pass = 0;
  int    n_tot  = 0;

  range_step_counter #(.SIZE(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .init_value (init_value),
    .step       (step),
    .lo_limit   (lo_limit),
    .hi_limit   (hi_limit),
    .mode       (mode),
`ifdef RANGE_CNT_PRESCALE_EN
    .prescale   (prescale),
`endif
    .data       (data),
    .co         (co),
    .bnd        (bnd),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Apply one cycle of stimulus, queue the expected post-edge state,
  // then compare against the DUT just after the edge.
  task automatic cyc(
    input string tag,
    input bit r, ld, e, u,
    input logic [7:0] lv, stp, lo, hi,
    input logic [1:0] md,
    input logic [7:0] e_data,
    input bit e_bnd, e_done, e_co
  );
    exp_t x;
    rst = r; load = ld; en = e; up = u;
    load_value = lv; step = stp;
    lo_limit = lo; hi_limit = hi; mode = md;
    sb_q.push_back('{e_data, e_bnd, e_done, e_co});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      x   = sb_q.pop_front();
      tag = tag_q.pop_front();
      chk({tag, "_data"}, int'(data), int'(x.data));
      chk({tag, "_bnd"},  int'(bnd),  int'(x.bnd));
      chk({tag, "_done"}, int'(done), int'(x.done));
      chk({tag, "_co"},   int'(co),   int'(x.co));
    end
  endtask

  initial begin
    init_value = 8'd5;
`ifdef RANGE_CNT_PRESCALE_EN
    prescale = 4'd0;
`endif
    // Reset
    cyc("rst",   1,0,0,1, 0,3,2,10, 0,  5,0,0,0);
    // Wrap up, step 3, window [2,10]
    cyc("w_ld",  0,1,0,1, 2,3,2,10, 0,  2,0,0,0);
    cyc("w_1",   0,0,1,1, 0,3,2,10, 0,  5,0,0,0);
    cyc("w_2",   0,0,1,1, 0,3,2,10, 0,  8,0,0,0);
    cyc("w_3",   0,0,1,1, 0,3,2,10, 0,  2,1,0,0);
    cyc("w_4",   0,0,1,1, 0,3,2,10, 0,  5,0,0,0);
    // Reset while counting
    cyc("rst_m", 1,0,1,1, 0,3,2,10, 0,  5,0,0,0);
    // Saturate down, step 4, window [3,20]
    cyc("s_ld",  0,1,0,0, 9,4,3,20, 1,  9,0,0,0);
    cyc("s_1",   0,0,1,0, 0,4,3,20, 1,  5,0,0,0);
    cyc("s_2",   0,0,1,0, 0,4,3,20, 1,  3,1,0,1);
    cyc("s_3",   0,0,1,0, 0,4,3,20, 1,  3,1,0,1);
    cyc("s_hld", 0,0,0,0, 0,4,3,20, 1,  3,0,0,1);
    // One-shot up across 255, no overflow to 0
    cyc("o_ld",  0,1,0,1, 254,1,0,255, 2,  254,0,0,0);
    cyc("o_1",   0,0,1,1, 0,1,0,255,   2,  255,0,0,1);
    cyc("o_2",   0,0,1,1, 0,1,0,255,   2,  255,1,1,1);
    cyc("o_frz", 0,0,1,1, 0,1,0,255,   2,  255,0,1,1);
    cyc("o_ld7", 0,1,1,1, 7,1,0,255,   2,  7,0,0,0);
    cyc("o_3",   0,0,1,1, 0,1,0,255,   2,  8,0,0,0);
    // Load beats counting; reset beats load
    cyc("ld_en", 0,1,1,1, 40,1,0,255, 0,  40,0,0,0);
    cyc("rs_ld", 1,1,1,1, 40,1,0,255, 0,  5,0,0,0);
    // Step 0 inside window holds
    cyc("z_in",  0,0,1,1, 0,0,0,255, 0,  5,0,0,0);
    // Step 0 above window: immediate boundary, wrap to lo
    cyc("z_ld",  0,1,0,1, 50,0,0,10, 0,  50,0,0,0);
    cyc("z_out", 0,0,1,1, 0,0,0,10,  0,  0,1,0,0);
    // Down with borrow wraps to hi
    cyc("b_ld",  0,1,0,0, 1,3,0,200, 0,  1,0,0,0);
    cyc("b_1",   0,0,1,0, 0,3,0,200, 0,  200,1,0,0);
    // Up from below window counts normally
    cyc("u_ld",  0,1,0,1, 5,4,20,30, 0,  5,0,0,0);
    cyc("u_1",   0,0,1,1, 0,4,20,30, 0,  9,0,0,0);
`ifdef RANGE_CNT_PRESCALE_EN
    // Prescale 2: one count every third enabled cycle
    prescale = 4'd2;
    cyc("p_ld",  0,1,0,1, 0,1,0,255, 0,  0,0,0,0);
    cyc("p_1",   0,0,1,1, 0,1,0,255, 0,  0,0,0,0);
    cyc("p_2",   0,0,1,1, 0,1,0,255, 0,  0,0,0,0);
    cyc("p_3",   0,0,1,1, 0,1,0,255, 0,  1,0,0,0);
    cyc("p_4",   0,0,1,1, 0,1,0,255, 0,  1,0,0,0);
    cyc("p_5",   0,0,1,1, 0,1,0,255, 0,  1,0,0,0);
    cyc("p_6",   0,0,1,1, 0,1,0,255, 0,  2,0,0,0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
